imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the byte-addressed, synchronous-read instruction memory. It owns the fetch PC and drives the memory read address. It tracks the one-cycle read latency and presents 32-bit instructions to the decode stage over a valid/ready handshake. It also handles stalls, halt, branch/jump redirects, and bad-address faults.

---
 rtl/imem_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, tracks the one-cycle
// memory latency and feeds decode through an output register plus skid.
module imem_fetch_ctrl #(
  parameter int                ADDR_W    = 7,
  parameter int                MEM_BYTES = 76,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fault
);

  typedef enum logic {
    RUN,
    FAULT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - 4);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic              skid_valid;
  logic [31:0]       skid_data;
  logic [ADDR_W-1:0] skid_pc;

  logic              pop;
  logic [2:0]        occ;
  logic              try_issue;
  logic              issue;
  logic              pc_legal;
  logic              tgt_legal;

  function automatic logic is_legal(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_PC);
  endfunction

  assign mem_addr = pc;

  always_comb begin
    pop       = instr_valid & instr_ready;
    occ       = 3'(instr_valid) + 3'(skid_valid)
              + 3'(inflight) - 3'(pop);
    pc_legal  = is_legal(pc);
    tgt_legal = is_legal(redirect_pc);
    // Everything except PC legality; an illegal PC here means fault.
    try_issue = (state == RUN) && !halt
              && !redirect_valid && (occ < 3'd2);
    issue     = try_issue && pc_legal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_pc     <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fault       <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      inflight    <= 1'b0;
      skid_valid  <= 1'b0;
      instr_valid <= 1'b0;
      state       <= tgt_legal ? RUN : FAULT;
      fault       <= !tgt_legal;
    end else begin
      inflight    <= issue;
      inflight_pc <= pc;
      if (issue) begin
        pc <= pc + STEP;
      end else if (try_issue) begin
        state <= FAULT;
        fault <= 1'b1;
      end
      // Skid drains first so ordering is preserved.
      if (!instr_valid || pop) begin
        if (skid_valid) begin
          instr       <= skid_data;
          instr_pc    <= skid_pc;
          instr_valid <= 1'b1;
          skid_valid  <= inflight;
          if (inflight) begin
            skid_data <= mem_data;
            skid_pc   <= inflight_pc;
          end
        end else if (inflight) begin
          instr       <= mem_data;
          instr_pc    <= inflight_pc;
          instr_valid <= 1'b1;
        end else begin
          instr_valid <= 1'b0;
        end
      end else if (inflight) begin
        skid_valid <= 1'b1;
        skid_data  <= mem_data;
        skid_pc    <= inflight_pc;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  mem_addr;
  logic [31:0] mem_data = '0;
  logic        redirect_valid = 1'b0;
  logic [6:0]  redirect_pc = '0;
  logic        halt = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [6:0]  instr_pc;
  logic        fault;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [32];

  // model state
  logic [6:0] q[$];
  bit         m_infl;
  logic [6:0] m_infl_pc;
  logic [6:0] m_pc;
  bit         m_fault;
  bit         m_rst;

  imem_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr[6:2]];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [6:0] a);
    return (a[1:0] == 2'b00) && (int'(a) <= 72);
  endfunction

  task automatic model_step(input bit r, input bit rv,
                            input logic [6:0] rpc,
                            input bit h, input bit rdy);
    bit pop;
    int occ;
    m_rst = r;
    if (r) begin
      q.delete();
      m_infl  = 0;
      m_pc    = 7'd0;
      m_fault = 0;
    end else if (rv) begin
      q.delete();
      m_infl  = 0;
      m_pc    = rpc;
      m_fault = !legal(rpc);
    end else begin
      pop = (q.size() > 0) && rdy;
      occ = q.size() + int'(m_infl) - int'(pop);
      if (pop) void'(q.pop_front());
      if (m_infl) q.push_back(m_infl_pc);
      m_infl = 0;
      if (!m_fault && !h && occ < 2) begin
        if (legal(m_pc)) begin
          m_infl    = 1;
          m_infl_pc = m_pc;
          m_pc      = m_pc + 7'd4;
        end else begin
          m_fault = 1;
        end
      end
    end
  endtask

  task automatic compare();
    check("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
    check("mem_addr", 32'(mem_addr), 32'(m_pc));
    check("fault", 32'(fault), 32'(m_fault));
    if (q.size() > 0) begin
      check("instr_pc", 32'(instr_pc), 32'(q[0]));
      check("instr", instr, mem[q[0][6:2]]);
    end
    if (m_rst) begin
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", 32'(instr_pc), 32'd0);
    end
  endtask

  task automatic cyc(input bit r, input bit rv,
                     input logic [6:0] rpc,
                     input bit h, input bit rdy);
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    instr_ready    = rdy;
    model_step(r, rv, rpc, h, rdy);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n, input bit h, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 7'd0, h, rdy);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    @(negedge clk);
    // reset and streaming
    cyc(1, 0, 7'd0, 0, 1);
    cyc(1, 0, 7'd0, 0, 1);
    run(3, 0, 1);
    // backpressure after W1
    cyc(1, 0, 7'd0, 0, 1);
    run(2, 0, 1);
    run(5, 0, 0);
    run(6, 0, 1);
    // redirect while streaming
    cyc(0, 1, 7'd40, 0, 1);
    run(4, 0, 1);
    // halt at pc 20
    cyc(0, 1, 7'd20, 1, 1);
    run(4, 1, 1);
    run(4, 0, 1);
    // range fault then recovery
    cyc(0, 1, 7'd64, 0, 1);
    run(8, 0, 1);
    run(3, 0, 0);
    cyc(0, 1, 7'd0, 0, 1);
    run(4, 0, 1);
    // alignment fault then reset
    cyc(0, 1, 7'd6, 0, 1);
    run(3, 0, 1);
    cyc(1, 0, 7'd0, 0, 1);
    run(4, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, rv, h, rdy;
      logic [6:0] t;
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      h   = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0)
        t = 7'($urandom);
      else
        t = 7'($urandom_range(0, 18) * 4);
      cyc(r, rv, t, h, rdy);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
